// File: rtl/md_unit_ctrl.sv
// Multiply/divide controller for the E stage: computes a result into a staging
// register at command accept and commits it to HI/LO when the latency counter expires.
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MTHI  = 4'b0101;
    localparam logic [3:0] OP_MTLO  = 4'b0110;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      hi_t_q, hi_t_d, lo_t_q, lo_t_d;

    logic signed [63:0] a_sx, b_sx, prod_s;
    logic [63:0]        prod_u;
    logic               div_by_zero, div_ovf;
    logic signed [31:0] a_s, b_s, quot_s, rem_s;
    logic [31:0]        div_b_u, quot_u, rem_u;

    assign a_sx   = {{32{A[31]}}, A};
    assign b_sx   = {{32{B[31]}}, B};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Dividing by 1 in the overflow case yields exactly quotient 0x80000000,
    // remainder 0, and keeps the divider free of the INT_MIN/-1 corner.
    assign div_by_zero = (B == 32'd0);
    assign div_ovf     = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    assign div_b_u     = div_by_zero ? 32'd1 : B;
    assign a_s         = $signed(A);
    assign b_s         = (div_by_zero || div_ovf) ? 32'sd1 : $signed(B);
    assign quot_s      = a_s / b_s;
    assign rem_s       = a_s % b_s;
    assign quot_u      = A / div_b_u;
    assign rem_u       = A % div_b_u;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_t_d  = hi_t_q;
        lo_t_d  = lo_t_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (MDOp)
                        OP_MULT: begin
                            hi_t_d  = prod_s[63:32];
                            lo_t_d  = prod_s[31:0];
                            cnt_d   = MULT_LOAD;
                            state_d = S_BUSY;
                        end
                        OP_MULTU: begin
                            hi_t_d  = prod_u[63:32];
                            lo_t_d  = prod_u[31:0];
                            cnt_d   = MULT_LOAD;
                            state_d = S_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero stages the current HI/LO so the commit is a no-op.
                            if (div_by_zero) begin
                                hi_t_d = hi_q;
                                lo_t_d = lo_q;
                            end else if (MDOp == OP_DIV) begin
                                hi_t_d = $unsigned(rem_s);
                                lo_t_d = $unsigned(quot_s);
                            end else begin
                                hi_t_d = rem_u;
                                lo_t_d = quot_u;
                            end
                            cnt_d   = DIV_LOAD;
                            state_d = S_BUSY;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    hi_d    = hi_t_q;
                    lo_d    = lo_t_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            hi_t_q  <= '0;
            lo_t_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_t_q  <= hi_t_d;
            lo_t_q  <= lo_t_d;
        end
    end

    assign busy = (state_q == S_BUSY);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl: directed scenarios plus randomized
// traffic compared against an arithmetic reference model.
module tb_md_unit_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  MDOp = 4'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy;
    logic [31:0] HI, LO;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
    bit          p_wr = 1'b0;
    int          m_left = 0;

    md_unit_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .MDOp(MDOp),
        .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    function automatic void model_edge();
        logic signed [63:0] sa, sb, sp, q, r;
        logic [63:0]        up;
        sa = {{32{A[31]}}, A};
        sb = {{32{B[31]}}, B};
        if (reset == 1'b0) begin
            m_hi = 0; m_lo = 0; m_left = 0; p_wr = 0; p_hi = 0; p_lo = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && p_wr) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (start) begin
            case (MDOp)
                4'd1: begin sp = sa * sb; p_hi = sp[63:32]; p_lo = sp[31:0]; p_wr = 1; m_left = MULT_N; end
                4'd2: begin up = {32'd0, A} * {32'd0, B}; p_hi = up[63:32]; p_lo = up[31:0]; p_wr = 1; m_left = MULT_N; end
                4'd3: begin
                    if (B == 0) p_wr = 0;
                    else begin q = sa / sb; r = sa % sb; p_lo = q[31:0]; p_hi = r[31:0]; p_wr = 1; end
                    m_left = DIV_N;
                end
                4'd4: begin
                    if (B == 0) p_wr = 0;
                    else begin p_lo = A / B; p_hi = A % B; p_wr = 1; end
                    m_left = DIV_N;
                end
                4'd5: m_hi = A;
                4'd6: m_lo = A;
                default: ;
            endcase
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; MDOp = op; A = a; B = b;
        tick();
        start = 1'b0; MDOp = 4'd0; A = $urandom; B = $urandom;
    endtask

    // Counts busy cycles (bounded) and flags any HI/LO change before commit.
    task automatic run_busy(output int n, output bit early);
        logic [31:0] h0, l0;
        h0 = HI; l0 = LO; n = 0; early = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick();
            if (busy === 1'b1 && (HI !== h0 || LO !== l0)) early = 1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (HI !== 32'd0) begin failures++; $display("FAIL reset_hi: got %h want 0", HI); end
        checks++; if (LO !== 32'd0) begin failures++; $display("FAIL reset_lo: got %h want 0", LO); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        int n; bit e;
        issue(4'd1, 32'hFFFF_FFFE, 32'd3);
        run_busy(n, e);
        checks++; if (n != MULT_N) begin failures++; $display("FAIL mult_cycles: got %0d want %0d", n, MULT_N); end
        checks++; if (e) begin failures++; $display("FAIL mult_early: got 1 want 0"); end
        checks++; if (HI !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi: got %h want ffffffff", HI); end
        checks++; if (LO !== 32'hFFFF_FFFA) begin failures++; $display("FAIL mult_lo: got %h want fffffffa", LO); end
    endtask

    task automatic test_multu();
        int n; bit e;
        issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_busy(n, e);
        checks++; if (n != MULT_N) begin failures++; $display("FAIL multu_cycles: got %0d want %0d", n, MULT_N); end
        checks++; if (HI !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_hi: got %h want fffffffe", HI); end
        checks++; if (LO !== 32'h0000_0001) begin failures++; $display("FAIL multu_lo: got %h want 00000001", LO); end
    endtask

    task automatic test_div();
        int n; bit e;
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        run_busy(n, e);
        checks++; if (n != DIV_N) begin failures++; $display("FAIL div_cycles: got %0d want %0d", n, DIV_N); end
        checks++; if (e) begin failures++; $display("FAIL div_early: got 1 want 0"); end
        checks++; if (LO !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_lo: got %h want fffffffd", LO); end
        checks++; if (HI !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_hi: got %h want ffffffff", HI); end
    endtask

    task automatic test_div_special();
        int n; bit e;
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run_busy(n, e);
        checks++; if (LO !== 32'h8000_0000) begin failures++; $display("FAIL divovf_lo: got %h want 80000000", LO); end
        checks++; if (HI !== 32'h0) begin failures++; $display("FAIL divovf_hi: got %h want 00000000", HI); end
        issue(4'd4, 32'd5, 32'd0);
        run_busy(n, e);
        checks++; if (n != DIV_N) begin failures++; $display("FAIL divz_cycles: got %0d want %0d", n, DIV_N); end
        checks++; if (HI !== 32'h0) begin failures++; $display("FAIL divz_hi: got %h want 00000000", HI); end
        checks++; if (LO !== 32'h8000_0000) begin failures++; $display("FAIL divz_lo: got %h want 80000000", LO); end
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] lo0;
        lo0 = LO;
        issue(4'd5, 32'h1234_5678, 32'd0);
        checks++; if (HI !== 32'h1234_5678) begin failures++; $display("FAIL mthi_hi: got %h want 12345678", HI); end
        checks++; if (LO !== lo0) begin failures++; $display("FAIL mthi_lo: got %h want %h", LO, lo0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mthi_busy: got %b want 0", busy); end
        issue(4'd6, 32'h9ABC_DEF0, 32'd0);
        checks++; if (LO !== 32'h9ABC_DEF0) begin failures++; $display("FAIL mtlo_lo: got %h want 9abcdef0", LO); end
        checks++; if (HI !== 32'h1234_5678) begin failures++; $display("FAIL mtlo_hi: got %h want 12345678", HI); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mtlo_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        issue(4'd1, 32'd7, 32'hFFFF_FFFD);
        // Hold a competing multu through every busy edge, including the falling one.
        start = 1'b1; MDOp = 4'd2; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
        for (int i = 0; i < MULT_N; i++) tick();
        start = 1'b0; MDOp = 4'd0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy: got %b want 0", busy); end
        checks++; if (HI !== 32'hFFFF_FFFF) begin failures++; $display("FAIL b2b_hi: got %h want ffffffff", HI); end
        checks++; if (LO !== 32'hFFFF_FFEB) begin failures++; $display("FAIL b2b_lo: got %h want ffffffeb", LO); end
        issue(4'd5, 32'hCAFE_F00D, 32'd0);
        checks++; if (HI !== 32'hCAFE_F00D) begin failures++; $display("FAIL b2b_next_hi: got %h want cafef00d", HI); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_next_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        issue(4'd4, 32'd100, 32'd7);
        tick(); tick(); tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        checks++; if (HI !== 32'd0) begin failures++; $display("FAIL rstmid_hi: got %h want 0", HI); end
        checks++; if (LO !== 32'd0) begin failures++; $display("FAIL rstmid_lo: got %h want 0", LO); end
        for (int i = 0; i < 12; i++) tick();
        checks++; if (HI !== 32'd0 || LO !== 32'd0) begin failures++; $display("FAIL rstmid_nocommit: got %h/%h want 0/0", HI, LO); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy_late: got %b want 0", busy); end
    endtask

    task automatic test_random();
        int sel;
        for (int c = 0; c < 600; c++) begin
            start = ($urandom_range(0, 2) == 0);
            MDOp  = 4'($urandom_range(0, 8));
            sel = $urandom_range(0, 9);
            A = (sel == 0) ? 32'h8000_0000 : (sel == 1) ? 32'($urandom_range(0, 50)) : $urandom;
            sel = $urandom_range(0, 9);
            B = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF : (sel == 2) ? 32'($urandom_range(1, 9)) : $urandom;
            reset = ($urandom_range(0, 149) != 0);
            tick();
            checks++; if (busy !== (m_left > 0)) begin failures++; $display("FAIL rand_busy@%0d: got %b want %b", c, busy, (m_left > 0)); end
            checks++; if (HI !== m_hi) begin failures++; $display("FAIL rand_hi@%0d: got %h want %h", c, HI, m_hi); end
            checks++; if (LO !== m_lo) begin failures++; $display("FAIL rand_lo@%0d: got %h want %h", c, LO, m_lo); end
        end
        reset = 1'b1; start = 1'b0; MDOp = 4'd0;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_special();
        test_mthi_mtlo();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md_unit_ctrl.md
# md_unit_ctrl

Multi-cycle multiply/divide controller for the CPU's E stage. It accepts mult/multu/div/divu/mthi/mtlo commands and sequences a fixed-latency operation. It holds HI/LO and raises `busy` so the hazard unit can stall later HI/LO users. Results are computed combinationally into a staging register and committed to HI/LO only when the latency counter expires.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu, minimum 1.
- `DIV_CYCLES`, default 10: busy cycles for div/divu, minimum 1.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low; `reset`==0 at a rising edge resets the block.
- `start`  in  1  command valid for this cycle.
- `MDOp`  in  4  command: 0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 0110 mtlo; others reserved.
- `A`  in  32  rs operand (dividend / multiplicand / mthi-mtlo data).
- `B`  in  32  rt operand (divisor / multiplier).
- `busy`  out  1  high while an operation is in flight.
- `HI`  out  32  architectural HI register.
- `LO`  out  32  architectural LO register.

## Operation
- States: IDLE, BUSY. Reset → IDLE, `busy`=0, `HI`=0, `LO`=0, counter=0, staging=0.
- IDLE, `start`=1, MDOp mult/multu/div/divu:
  - Capture the result into staging {hi_t, lo_t}.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Go to BUSY.
- IDLE, `start`=1, mthi: `HI`←`A` at the same edge. mtlo: `LO`←`A`. State stays IDLE and `busy` stays 0.
- IDLE, `start`=1, op none/reserved: no state change.
- BUSY: decrement the counter each edge. On the edge where the counter goes 1→0, commit staging to HI/LO and return to IDLE.
- BUSY, `start`=1 (any op): ignored entirely. The hazard unit stalls on `busy`, so this is not an error.
- Arithmetic:
  - mult: {HI,LO} = signed(A)×signed(B), 64-bit.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient to LO, remainder to HI.
  - div with A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (div/divu, B=0): the operation still runs full latency with `busy`, but HI/LO stay unchanged at commit.
- Reset mid-operation: the in-flight result is discarded and every output returns to its reset value at that edge.

## Timing
- `start` is sampled at edge E0.
- mult/multu: `busy`=1 from after E0 through E0+MULT_CYCLES. At edge E0+MULT_CYCLES, `busy` falls and HI/LO update in the same edge.
- div/divu: same rule with DIV_CYCLES.
- mthi/mtlo: 1-edge latency, HI/LO visible after E0, `busy` never asserted.
- A new command is accepted on the same edge `busy` falls? No. That edge is still in BUSY, so the command is ignored. The earliest accepted new `start` is at edge E0+N+1.
- `busy`, `HI`, `LO` are registered outputs with no combinational path from inputs.
- Operands are sampled only at E0. Changes to `A`/`B` during BUSY have no effect.

## Test plan
- Reset, then mult A=0xFFFFFFFE(−2), B=3 → `busy`=1 for exactly 5 cycles. After that: HI=0xFFFFFFFF, LO=0xFFFFFFFA, `busy`=0.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div A=0xFFFFFFF9(−7), B=2 → `busy` for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0. After that, divu A=5, B=0 → 10 busy cycles and HI/LO unchanged.
- mthi A=0x12345678 then next cycle mtlo A=0x9ABCDEF0 → HI/LO updated one edge each, `busy` stays 0. Then start multu while a prior mult is BUSY → second command ignored and only the first result is committed.
- Start divu A=100, B=7; assert `reset`=0 at cycle 4 → next cycle `busy`=0, HI=LO=0. No commit occurs at the original cycle 10.
